// File: rtl/ballot_pkg.sv
// Shared definitions for the 4-voter ballot collection path: FSM states,
// the evaluator's one-hot result codes and the voter count.
package ballot_pkg;

    localparam int NUM_VOTERS = 4;

    localparam logic [2:0] RES_REJECT  = 3'b001;
    localparam logic [2:0] RES_TIE     = 3'b010;
    localparam logic [2:0] RES_APPROVE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ISSUE,
        ST_DONE
    } state_e;

    // True when the evaluator produced one of the three legal one-hot codes.
    function automatic logic is_valid_result(input logic [2:0] r);
        return (r == RES_REJECT) || (r == RES_TIE) || (r == RES_APPROVE);
    endfunction

endpackage

// File: rtl/ballot_collector_if.sv
// Vote strobe and evaluator connection of the ballot collector.
// master = the side that casts votes and drives the evaluator result,
// slave  = the collector itself.
interface ballot_collector_if;
    import ballot_pkg::*;

    logic                  vote_valid;
    logic [1:0]            vote_id;
    logic                  vote_yes;
    logic                  dup_err;
    logic [NUM_VOTERS-1:0] ballot;
    logic                  ballot_valid;
    logic [2:0]            result;

    modport master (
        output vote_valid, vote_id, vote_yes, result,
        input  dup_err, ballot, ballot_valid
    );

    modport slave (
        input  vote_valid, vote_id, vote_yes, result,
        output dup_err, ballot, ballot_valid
    );

endinterface

// File: rtl/ballot_collector_sat_counter.sv
// W-bit tally counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc until the maximum value is reached, then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ballot_collector.sv
// Collects one yes/no vote per voter per round, presents the finished
// ballot to the evaluator for one cycle, latches its decision and tallies
// round outcomes.
// Optional feature: define BALLOT_TIMEOUT_EN to force issue of a partial
// ballot after TIMEOUT_CYC cycles in COLLECT (adds the timed_out port).
module ballot_collector
    import ballot_pkg::*;
#(
    parameter int CNT_W = 8
`ifdef BALLOT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    ballot_collector_if.slave  bus,
    output logic [2:0]         decision,
    output logic               result_err,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   approve_cnt,
    output logic [CNT_W-1:0]   tie_cnt,
    output logic [CNT_W-1:0]   reject_cnt
`ifdef BALLOT_TIMEOUT_EN
    ,
    output logic               timed_out
`endif
);

    state_e                state_q, state_d;
    logic [NUM_VOTERS-1:0] voted_q, voted_next;
    logic [NUM_VOTERS-1:0] ballot_q;
    logic                  dup_q;
    logic [2:0]            decision_q;
    logic                  result_err_q;
    logic                  enter_collect;
    logic                  vote_new;
    logic                  vote_dup;
    logic                  in_issue;

`ifdef BALLOT_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timed_out_q;
    logic             timeout_hit;
`endif

    assign in_issue = (state_q == ST_ISSUE);

    // Next-state decode and per-cycle vote classification.
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d       = state_q;
        enter_collect = 1'b0;
        vote_new      = 1'b0;
        vote_dup      = 1'b0;
        voted_next    = voted_q;
`ifdef BALLOT_TIMEOUT_EN
        timeout_hit   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_COLLECT;
                    enter_collect = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (bus.vote_valid) begin
                    if (voted_q[bus.vote_id]) begin
                        vote_dup = 1'b1;
                    end else begin
                        vote_new                = 1'b1;
                        voted_next[bus.vote_id] = 1'b1;
                    end
                end
                // A vote that completes the mask wins over a coincident timeout.
                if (voted_next == '1) begin
                    state_d = ST_ISSUE;
                end
`ifdef BALLOT_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = ST_ISSUE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            ST_ISSUE: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Round data: voted mask, ballot bits, duplicate pulse, decision and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            voted_q      <= '0;
            ballot_q     <= '0;
            dup_q        <= 1'b0;
            decision_q   <= '0;
            result_err_q <= 1'b0;
        end else begin
            dup_q <= vote_dup;
            if (enter_collect) begin
                voted_q      <= '0;
                ballot_q     <= '0;
                result_err_q <= 1'b0;
            end else if (vote_new) begin
                voted_q           <= voted_next;
                ballot_q[bus.vote_id] <= bus.vote_yes;
            end
            if (in_issue) begin
                decision_q <= bus.result;
                if (!is_valid_result(bus.result)) begin
                    result_err_q <= 1'b1;
                end
            end
        end
    end

`ifdef BALLOT_TIMEOUT_EN
    // COLLECT cycle counter and sticky timeout flag, both cleared on round start.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q   <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (enter_collect) begin
                tmo_cnt_q   <= '0;
                timed_out_q <= 1'b0;
            end else begin
                if (state_q == ST_COLLECT) begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                end
                if (timeout_hit) begin
                    timed_out_q <= 1'b1;
                end
            end
        end
    end

    assign timed_out = timed_out_q;
`endif

    sat_counter #(.W(CNT_W)) u_approve_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_issue && (bus.result == RES_APPROVE)),
        .count (approve_cnt)
    );

    sat_counter #(.W(CNT_W)) u_tie_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_issue && (bus.result == RES_TIE)),
        .count (tie_cnt)
    );

    sat_counter #(.W(CNT_W)) u_reject_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_issue && (bus.result == RES_REJECT)),
        .count (reject_cnt)
    );

    assign bus.ballot       = ballot_q;
    assign bus.ballot_valid = in_issue;
    assign bus.dup_err      = dup_q;
    assign decision         = decision_q;
    assign result_err       = result_err_q;
    assign busy             = (state_q == ST_COLLECT) || in_issue;
    assign done             = (state_q == ST_DONE);

endmodule

// File: tb/tb_ballot_collector.sv
// Self-checking bench for ballot_collector: directed rounds followed by
// randomized rounds, checked against a vote-level reference model through
// a scoreboard. Honours BALLOT_TIMEOUT_EN when defined.
module tb_ballot_collector;
    import ballot_pkg::*;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef BALLOT_TIMEOUT_EN
    localparam int TMO = 8;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       decision;
    logic             result_err;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] approve_cnt, tie_cnt, reject_cnt;
`ifdef BALLOT_TIMEOUT_EN
    logic             timed_out;
`endif

    ballot_collector_if bus ();

    ballot_collector #(
        .CNT_W       (CNT_W)
`ifdef BALLOT_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (TMO)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .decision    (decision),
        .result_err  (result_err),
        .busy        (busy),
        .done        (done),
        .approve_cnt (approve_cnt),
        .tie_cnt     (tie_cnt),
        .reject_cnt  (reject_cnt)
`ifdef BALLOT_TIMEOUT_EN
        ,
        .timed_out   (timed_out)
`endif
    );

    always #5 clk = ~clk;

    // Interval index: bumps at every rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [3:0] ballot;
        logic [2:0] decision;
        logic       err;
        logic       tmo;
        int         app;
        int         tie;
        int         rej;
    } exp_t;

    exp_t exp_q[$];
    int   dup_q[$];

    // Reference model state: outcome tallies.
    int m_app = 0, m_tie = 0, m_rej = 0;

    // Directed vote plan consumed by the next round; random votes once empty.
    bit         plan_v[$];
    logic [1:0] plan_id[$];
    logic       plan_yes[$];

    function automatic logic [2:0] evaluate(input logic [3:0] b);
        int yes = $countones(b);
        if (yes > 2)  return RES_APPROVE;
        if (yes == 2) return RES_TIE;
        return RES_REJECT;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full round starting from IDLE or DONE; returns in the DONE interval.
    task automatic run_round(input bit rand_res, input logic [2:0] fixed_res);
        bit         voted[4];
        logic [3:0] bal;
        int         ncoll;
        bit         full, tmo;
        logic       v, y;
        logic [1:0] id;
        logic [2:0] res;
        exp_t       e;

        // A vote presented with start is dropped.
        start          = 1'b1;
        bus.vote_valid = 1'($urandom_range(0, 1));
        bus.vote_id    = 2'($urandom_range(0, 3));
        bus.vote_yes   = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        bal   = '0;
        for (int i = 0; i < 4; i++) voted[i] = 1'b0;
        ncoll = 0;
        full  = 1'b0;
        tmo   = 1'b0;
        res   = fixed_res;
        while (!full && !tmo) begin
            ncoll++;
            if (plan_v.size() > 0) begin
                v  = plan_v.pop_front();
                id = plan_id.pop_front();
                y  = plan_yes.pop_front();
            end else begin
                v  = ($urandom_range(0, 3) != 0);
                id = 2'($urandom_range(0, 3));
                y  = 1'($urandom_range(0, 1));
                if (ncoll > 40) begin
                    v = 1'b1;
                    for (int i = 3; i >= 0; i--) if (!voted[i]) id = 2'(i);
                end
            end
            start          = ($urandom_range(0, 7) == 0);
            bus.vote_valid = v;
            bus.vote_id    = id;
            bus.vote_yes   = y;
            if (v) begin
                if (voted[id]) begin
                    dup_q.push_back(cyc + 1);
                end else begin
                    voted[id] = 1'b1;
                    bal[id]   = y;
                end
            end
            full = voted[0] && voted[1] && voted[2] && voted[3];
`ifdef BALLOT_TIMEOUT_EN
            if (!full && ncoll == TMO) tmo = 1'b1;
`endif
            if (full || tmo) begin
                if (rand_res) begin
                    res = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : evaluate(bal);
                end
                if (res == RES_APPROVE) m_app = sat_inc(m_app);
                if (res == RES_TIE)     m_tie = sat_inc(m_tie);
                if (res == RES_REJECT)  m_rej = sat_inc(m_rej);
                e.cyc      = cyc + 1;
                e.ballot   = bal;
                e.decision = res;
                e.err      = !(res == RES_APPROVE || res == RES_TIE || res == RES_REJECT);
                e.tmo      = tmo;
                e.app      = m_app;
                e.tie      = m_tie;
                e.rej      = m_rej;
                exp_q.push_back(e);
            end
            tick();
        end
        // ISSUE interval: start and votes are ignored here.
        start          = 1'($urandom_range(0, 1));
        bus.vote_valid = 1'($urandom_range(0, 1));
        bus.vote_id    = 2'($urandom_range(0, 3));
        bus.result     = res;
        tick();
        // DONE interval.
        start          = 1'b0;
        bus.vote_valid = 1'($urandom_range(0, 1));
        bus.vote_id    = 2'($urandom_range(0, 3));
        bus.result     = 3'($urandom_range(0, 7));
    endtask

    task automatic plan_vote(input bit v, input logic [1:0] id, input logic y);
        plan_v.push_back(v);
        plan_id.push_back(id);
        plan_yes.push_back(y);
    endtask

    task automatic check_cleared(input string tag);
        @(negedge clk);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_done"},     done, 0);
        check({tag, "_ballot"},   bus.ballot, 0);
        check({tag, "_decision"}, decision, 0);
        check({tag, "_res_err"},  result_err, 0);
        check({tag, "_approve"},  approve_cnt, 0);
        check({tag, "_tie"},      tie_cnt, 0);
        check({tag, "_reject"},   reject_cnt, 0);
`ifdef BALLOT_TIMEOUT_EN
        check({tag, "_timed_out"}, timed_out, 0);
`endif
    endtask

    // Monitor: compares every cycle against the scoreboard queues.
    initial begin : monitor
        exp_t cur;
        bit   pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (dup_q.size() > 0 && dup_q[0] == cyc) begin
                check("dup_err_pulse", bus.dup_err, 1);
                void'(dup_q.pop_front());
            end else begin
                check("dup_err_quiet", bus.dup_err, 0);
            end
            if (pend) begin
                pend = 1'b0;
                check("done",        done, 1);
                check("busy_done",   busy, 0);
                check("ballot_held", bus.ballot, cur.ballot);
                check("decision",    decision, cur.decision);
                check("result_err",  result_err, cur.err);
                check("approve_cnt", approve_cnt, cur.app);
                check("tie_cnt",     tie_cnt, cur.tie);
                check("reject_cnt",  reject_cnt, cur.rej);
`ifdef BALLOT_TIMEOUT_EN
                check("timed_out",   timed_out, cur.tmo);
`endif
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                cur = exp_q.pop_front();
                check("ballot_valid", bus.ballot_valid, 1);
                check("ballot",       bus.ballot, cur.ballot);
                check("busy_issue",   busy, 1);
                pend = 1'b1;
            end else begin
                check("ballot_valid_quiet", bus.ballot_valid, 0);
            end
        end
    end

    // Stimulus.
    initial begin : driver
        rst            = 1'b1;
        start          = 1'b0;
        bus.vote_valid = 1'b0;
        bus.vote_id    = 2'd0;
        bus.vote_yes   = 1'b0;
        bus.result     = 3'b000;
        tick();
        tick();
        check_cleared("reset");
        rst = 1'b0;

        // Votes 1,1,1,0 evaluated as approve.
        plan_vote(1, 2'd0, 1); plan_vote(1, 2'd1, 1); plan_vote(1, 2'd2, 1); plan_vote(1, 2'd3, 0);
        run_round(1'b0, RES_APPROVE);
        tick(); tick();

        // Votes 1,0,1,0 evaluated as tie; start issued straight from DONE.
        plan_vote(1, 2'd0, 1); plan_vote(1, 2'd1, 0); plan_vote(1, 2'd2, 1); plan_vote(1, 2'd3, 0);
        run_round(1'b0, RES_TIE);

        // Duplicate vote on voter 2 is dropped; round waits for voter 3.
        plan_vote(1, 2'd0, 1); plan_vote(1, 2'd2, 1); plan_vote(1, 2'd2, 0);
        plan_vote(0, 2'd3, 1); plan_vote(1, 2'd1, 0); plan_vote(1, 2'd3, 1);
        run_round(1'b0, RES_APPROVE);

        // Non-one-hot evaluator output.
        plan_vote(1, 2'd3, 1); plan_vote(1, 2'd2, 0); plan_vote(1, 2'd1, 1); plan_vote(1, 2'd0, 0);
        run_round(1'b0, 3'b011);
        tick();

        // Reset with two votes collected discards the round and the tallies.
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.vote_valid = 1'b1; bus.vote_id = 2'd0; bus.vote_yes = 1'b1;
        tick();
        bus.vote_id = 2'd3;
        tick();
        bus.vote_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_app = 0; m_tie = 0; m_rej = 0;
        check_cleared("mid_reset");

`ifdef BALLOT_TIMEOUT_EN
        // Only voter 1 votes: partial ballot forced out by the timeout.
        plan_vote(1, 2'd1, 1);
        for (int i = 1; i < TMO; i++) plan_vote(0, 2'd0, 0);
        run_round(1'b0, RES_REJECT);
`endif

        // Randomized rounds; enough of them to saturate the narrow tallies.
        for (int r = 0; r < 60; r++) begin
            run_round(1'b1, 3'b000);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        check("dup_queue_drained",  dup_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ballot_collector.md
Name: ballot_collector

Overview:
- Front end of the 4-voter decision path. Collects one yes/no vote from each of 4 voters over multiple cycles, with a per-voter once-per-round rule.
- Presents the completed 4-bit ballot to the combinational vote evaluator and samples its one-hot result (001 reject, 010 tie, 100 approve).
- Latches the decision and keeps running tallies of round outcomes.

Parameters:
- CNT_W, 8, width of each outcome tally counter; counters saturate at 2^CNT_W-1.
- TIMEOUT_CYC, 64, max cycles spent in COLLECT before forced issue (used only with TIMEOUT_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a new round; honoured in IDLE and DONE only.
- vote_valid  input  1  vote strobe, one vote per cycle.
- vote_id  input  2  voter index 0..3; maps to ballot bit vote_id.
- vote_yes  input  1  1 = approve, 0 = reject.
- dup_err  output  1  1-cycle pulse: vote from a voter already counted this round; vote dropped.
- ballot  output  4  collected votes to evaluator input I.
- ballot_valid  output  1  high exactly one cycle (ISSUE) when ballot is final.
- result  input  3  evaluator output O[3:1], sampled during ISSUE.
- decision  output  3  latched result of the last completed round.
- result_err  output  1  sticky until next start: sampled result not one-hot.
- busy  output  1  high in COLLECT and ISSUE.
- done  output  1  high in DONE.
- approve_cnt, tie_cnt, reject_cnt  output  CNT_W each  round outcome tallies.
- timed_out  output  1  present only with TIMEOUT_EN.

Behaviour:
- Reset, one clock, synchronous active-high:
  - State goes to IDLE.
  - ballot, voted mask, decision, all counters, result_err and timed_out clear to 0.
  - dup_err and ballot_valid go to 0.
  - Reset mid-round discards the round; tallies are also cleared.
- States: IDLE, COLLECT, ISSUE, DONE.
- IDLE: start=1 -> COLLECT next cycle. On that entry, ballot=0000, voted=0000, result_err=0, timed_out=0.
- COLLECT:
  - vote_valid=1 with voted[vote_id]=0: set voted[vote_id]=1 and ballot[vote_id]=vote_yes on the same edge.
  - vote_valid=1 with voted[vote_id]=1: ballot unchanged; dup_err=1 the next cycle for one cycle.
  - When the mask including this cycle's vote reaches 1111 -> ISSUE next cycle. Minimum round: 4 vote cycles, then ISSUE.
  - start is ignored.
- ISSUE (exactly 1 cycle):
  - ballot_valid=1; ballot stable.
  - result is sampled on the closing edge into decision.
  - One-hot result: increment approve_cnt (100), tie_cnt (010) or reject_cnt (001), saturating.
  - Non-one-hot result: result_err=1 and no tally changes.
  - Always -> DONE.
- DONE:
  - done=1; decision and ballot held.
  - start=1 -> COLLECT with the same clears as the IDLE entry.
  - vote_valid is ignored in IDLE, ISSUE and DONE; no dup_err outside COLLECT.
- Simultaneous events: start with vote_valid on the entry cycle drops the vote; voting opens the cycle after entering COLLECT.

Optional Feature:
- Macro: BALLOT_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on COLLECT entry and increments each COLLECT cycle.
  - On reaching TIMEOUT_CYC without a full mask -> ISSUE, with unvoted bits left 0 (counted as reject). timed_out is set and held until the next start.
  - A vote completing the mask on the same cycle as the timeout wins: normal issue, timed_out=0.
- Undefined: COLLECT waits indefinitely; the timed_out port and the counter are absent.

Decomposition:
- Shared package ballot_pkg:
  - State enum.
  - One-hot result constants RES_REJECT=3'b001, RES_TIE=3'b010, RES_APPROVE=3'b100.
  - NUM_VOTERS=4.
- One natural sub-module: sat_counter (CNT_W-wide saturating increment), instantiated three times for the tallies.

Test Plan:
- Reset, start, votes id0=1, id1=1, id2=1, id3=0 on consecutive cycles -> ISSUE with ballot=0111, ballot_valid one cycle; with result=100 -> decision=100, approve_cnt=1.
- Round with votes 1,0,1,0 and evaluator result 010 -> tie_cnt=1; other counters unchanged; done=1 held.
- Duplicate vote id2 mid-round (second value 0 after first 1) -> dup_err pulse, ballot[2] stays 1; round issues only after id3 votes.
- Force result=011 during ISSUE -> result_err=1, all tallies unchanged, decision=011.
- Assert rst with 2 votes collected -> next cycle IDLE, ballot=0000, counters 0; following round behaves normally.
- With BALLOT_TIMEOUT_EN and TIMEOUT_CYC=8, only id1=1 voted -> ISSUE after cycle 8 with ballot=0010, timed_out=1; result 001 -> reject_cnt=1.
